// File: rtl/ram_pkg.sv
// Shared types and helpers for the parametrised dual-port RAM.
package ram_pkg;
  typedef enum logic {ST_IDLE, ST_CLEAR} state_e;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  // Per-byte merge: an enabled byte takes the new data, otherwise keeps the old.
  function automatic logic [7:0] byte_merge(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       be);
    return be ? new_b : old_b;
  endfunction
endpackage

// File: rtl/ram_clr_fsm.sv
// Clear engine: walks every address once, driving the array write mux while busy.
module ram_clr_fsm
  import ram_pkg::*;
#(
  parameter int ADDR_W        = 2,
  parameter bit INIT_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_sel,
  output logic [ADDR_W-1:0] clr_addr
);
  state_e            state, state_nxt;
  logic [ADDR_W-1:0] clr_addr_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INIT_ON_RESET ? ST_CLEAR : ST_IDLE;
      clr_addr <= '0;
    end else begin
      state    <= state_nxt;
      clr_addr <= clr_addr_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    clr_addr_nxt = clr_addr;
    case (state)
      ST_IDLE: begin
        if (clr_req) begin
          state_nxt    = ST_CLEAR;
          clr_addr_nxt = '0;
        end
      end
      ST_CLEAR: begin
        // Counter wraps to 0 on the same edge that writes the last word.
        clr_addr_nxt = clr_addr + ADDR_W'(1);
        if (clr_addr == '1) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy    = (state == ST_CLEAR);
  assign clr_sel = busy;
endmodule

// File: rtl/ram_dp_param.sv
// Simple dual-port RAM: byte-enabled write port, registered read port, built-in clear.
module ram_dp_param
  import ram_pkg::*;
#(
  parameter int DATA_W        = 8,
  parameter int ADDR_W        = 2,
  parameter int RDW_MODE      = RDW_READ_FIRST,
  parameter bit INIT_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_req,
  output logic                  busy,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W/8-1:0]   wr_be,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int BE_W  = DATA_W/8;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              clr_sel;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_go, rd_go;
  logic [DATA_W-1:0] wr_old, wr_merged, rd_word;

  ram_clr_fsm #(
    .ADDR_W        (ADDR_W),
    .INIT_ON_RESET (INIT_ON_RESET)
  ) u_clr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_sel  (clr_sel),
    .clr_addr (clr_addr)
  );

  // A clear request wins over a same-edge write; the read is still served.
  assign wr_go = wr_en && !busy && !clr_req;
  assign rd_go = rd_en && !busy;

  assign wr_old = mem[wr_addr];
  for (genvar b = 0; b < BE_W; b++) begin : g_lane
    assign wr_merged[8*b +: 8] = byte_merge(wr_old[8*b +: 8], wr_data[8*b +: 8], wr_be[b]);
  end

  always_comb begin
    rd_word = mem[rd_addr];
    if (RDW_MODE == RDW_WRITE_FIRST && wr_go && wr_addr == rd_addr) rd_word = wr_merged;
  end

  // Storage carries no reset; the clear engine is the only way to zero it.
  always_ff @(posedge clk) begin
    if (clr_sel)    mem[clr_addr] <= '0;
    else if (wr_go) mem[wr_addr]  <= wr_merged;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_go;
      if (rd_go) rd_data <= rd_word;
    end
  end
endmodule

// File: tb/tb_ram_dp_param.sv
// Randomised bench for ram_dp_param against an array-based reference model.
module tb_ram_dp_param;
  localparam int DATA_W        = 16;
  localparam int ADDR_W        = 2;
  localparam int DEPTH         = 4;
  localparam int BE_W          = 2;
  localparam int RDW_MODE      = 0;
  localparam bit INIT_ON_RESET = 1'b1;

  logic              clk, rst_n, clr_req, busy;
  logic              wr_en, rd_en, rd_valid;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [BE_W-1:0]   wr_be;
  logic [DATA_W-1:0] wr_data, rd_data;

  ram_dp_param #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RDW_MODE(RDW_MODE), .INIT_ON_RESET(INIT_ON_RESET)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int fails     = 0;
  logic [DATA_W-1:0] ref_mem [DEPTH];

  function automatic logic [DATA_W-1:0] model_merge(input logic [DATA_W-1:0] old_w,
                                                    input logic [DATA_W-1:0] new_w,
                                                    input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] r = old_w;
    for (int i = 0; i < BE_W; i++) if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clr_req = 0; wr_en = 0; rd_en = 0;
    wr_addr = 0; rd_addr = 0; wr_be = 0; wr_data = 0;
  endtask

  task automatic do_write(input int a, input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be);
    wr_en = 1; wr_addr = ADDR_W'(a); wr_data = d; wr_be = be;
    ref_mem[a] = model_merge(ref_mem[a], d, be);
    tick();
    wr_en = 0;
  endtask

  task automatic fill_nonzero();
    for (int a = 0; a < DEPTH; a++) do_write(a, DATA_W'($urandom) | 16'h0101, 2'b11);
  endtask

  task automatic test_reset();
    int n;
    idle_inputs();
    rst_n = 0;
    #12;
    tests_run++;
    if (rd_data !== 16'h0000 || rd_valid !== 1'b0) begin
      fails++; $display("FAIL reset_outputs: rd_data=%h rd_valid=%b, want 0000/0", rd_data, rd_valid);
    end
    tests_run++;
    if (busy !== INIT_ON_RESET) begin
      fails++; $display("FAIL reset_busy: got %b want %b", busy, INIT_ON_RESET);
    end
    rst_n = 1;
    n = 0;
    while (busy && n < 20) begin tick(); n++; end
    tests_run++;
    if (n != DEPTH) begin
      fails++; $display("FAIL auto_clear_len: busy cycles %0d want %0d", n, DEPTH);
    end
    for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;
    for (int a = 0; a < DEPTH; a++) begin
      rd_en = 1; rd_addr = ADDR_W'(a);
      tick();
      tests_run++;
      if (rd_valid !== 1'b1 || rd_data !== ref_mem[a]) begin
        fails++; $display("FAIL auto_clear_read[%0d]: got %h/%b want %h/1", a, rd_data, rd_valid, ref_mem[a]);
      end
    end
    rd_en = 0;
    tick();
    tests_run++;
    if (rd_valid !== 1'b0) begin
      fails++; $display("FAIL rd_valid_drop: got %b want 0", rd_valid);
    end
  endtask

  task automatic test_byte_enables();
    do_write(1, 16'hA5C3, 2'b11);
    do_write(1, 16'hFF00, 2'b01);
    rd_en = 1; rd_addr = 1;
    tick();
    rd_en = 0;
    tests_run++;
    if (rd_valid !== 1'b1 || rd_data !== ref_mem[1]) begin
      fails++; $display("FAIL byte_enables: got %h/%b want %h/1", rd_data, rd_valid, ref_mem[1]);
    end
    do_write(1, 16'h7777, 2'b00);
    rd_en = 1; rd_addr = 1;
    tick();
    rd_en = 0;
    tests_run++;
    if (rd_data !== ref_mem[1]) begin
      fails++; $display("FAIL be_zero_noop: got %h want %h", rd_data, ref_mem[1]);
    end
  endtask

  task automatic test_collision();
    logic [DATA_W-1:0] exp;
    do_write(2, 16'h1234, 2'b11);
    exp = (RDW_MODE == 1) ? model_merge(ref_mem[2], 16'hBEEF, 2'b10) : ref_mem[2];
    rd_en = 1; rd_addr = 2;
    do_write(2, 16'hBEEF, 2'b10);
    rd_en = 0;
    tests_run++;
    if (rd_valid !== 1'b1 || rd_data !== exp) begin
      fails++; $display("FAIL collision: got %h/%b want %h/1", rd_data, rd_valid, exp);
    end
    rd_en = 1; rd_addr = 2;
    tick();
    rd_en = 0;
    tests_run++;
    if (rd_data !== ref_mem[2]) begin
      fails++; $display("FAIL collision_after: got %h want %h", rd_data, ref_mem[2]);
    end
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] exp_rd;
    logic              exp_v;
    int                errs = 0;
    rd_en = 1; rd_addr = 0;
    exp_rd = ref_mem[0];
    tick();
    for (int k = 0; k < 300; k++) begin
      wr_en   = 1'($urandom);
      rd_en   = 1'($urandom);
      wr_addr = ADDR_W'($urandom);
      rd_addr = ADDR_W'($urandom);
      wr_data = DATA_W'($urandom);
      wr_be   = BE_W'($urandom);
      exp_v   = rd_en;
      if (rd_en)
        exp_rd = (RDW_MODE == 1 && wr_en && wr_addr == rd_addr)
               ? model_merge(ref_mem[rd_addr], wr_data, wr_be) : ref_mem[rd_addr];
      if (wr_en) ref_mem[wr_addr] = model_merge(ref_mem[wr_addr], wr_data, wr_be);
      tick();
      tests_run++;
      if (rd_valid !== exp_v || rd_data !== exp_rd) begin
        fails++; errs++;
        if (errs < 5) $display("FAIL random[%0d]: got %h/%b want %h/%b", k, rd_data, rd_valid, exp_rd, exp_v);
      end
    end
    idle_inputs();
  endtask

  task automatic test_clear_req();
    logic [DATA_W-1:0] exp;
    int n;
    fill_nonzero();
    exp = ref_mem[1];
    clr_req = 1; wr_en = 1; wr_addr = 0; wr_data = 16'hFFFF; wr_be = 2'b11;
    rd_en = 1; rd_addr = 1;
    tick();
    wr_en = 0;
    tests_run++;
    if (rd_valid !== 1'b1 || rd_data !== exp || busy !== 1'b1) begin
      fails++; $display("FAIL clr_req_edge: got %h/%b busy=%b want %h/1 busy=1", rd_data, rd_valid, busy, exp);
    end
    rd_addr = 3;
    n = 0;
    while (busy && n < 20) begin
      tick(); n++;
      tests_run++;
      if (rd_valid !== 1'b0 || rd_data !== exp) begin
        fails++; $display("FAIL busy_read: got %h/%b want %h/0", rd_data, rd_valid, exp);
      end
    end
    clr_req = 0; rd_en = 0;
    tests_run++;
    if (n != DEPTH) begin
      fails++; $display("FAIL clear_len: busy cycles %0d want %0d", n, DEPTH);
    end
    for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;
    for (int a = 0; a < DEPTH; a++) begin
      rd_en = 1; rd_addr = ADDR_W'(a);
      tick();
      tests_run++;
      if (rd_valid !== 1'b1 || rd_data !== ref_mem[a]) begin
        fails++; $display("FAIL clear_read[%0d]: got %h/%b want %h/1", a, rd_data, rd_valid, ref_mem[a]);
      end
    end
    rd_en = 0;
    tick();
  endtask

  task automatic test_reset_mid_clear();
    int n;
    fill_nonzero();
    rd_en = 1; rd_addr = 3;
    tick();
    clr_req = 1; rd_en = 0;
    tick();
    clr_req = 0;
    tick();
    rst_n = 0;
    rd_en = 1; rd_addr = 2;
    #1;
    tests_run++;
    if (rd_data !== 16'h0000 || rd_valid !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL midclear_reset: got %h/%b busy=%b want 0000/0 busy=1", rd_data, rd_valid, busy);
    end
    tick();
    tests_run++;
    if (rd_valid !== 1'b0 || rd_data !== 16'h0000) begin
      fails++; $display("FAIL read_in_reset: got %h/%b want 0000/0", rd_data, rd_valid);
    end
    rd_en = 0;
    @(negedge clk);
    rst_n = 1;
    n = 0;
    while (busy && n < 20) begin tick(); n++; end
    tests_run++;
    if (n != DEPTH) begin
      fails++; $display("FAIL midclear_restart_len: busy cycles %0d want %0d", n, DEPTH);
    end
    for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;
    for (int a = 0; a < DEPTH; a++) begin
      rd_en = 1; rd_addr = ADDR_W'(a);
      tick();
      tests_run++;
      if (rd_valid !== 1'b1 || rd_data !== ref_mem[a]) begin
        fails++; $display("FAIL midclear_read[%0d]: got %h/%b want %h/1", a, rd_data, rd_valid, ref_mem[a]);
      end
    end
    rd_en = 0;
    tick();
  endtask

  task automatic test_back_to_back();
    fill_nonzero();
    for (int i = 0; i < 8; i++) begin
      rd_en = 1; rd_addr = ADDR_W'(i);
      tick();
      tests_run++;
      if (rd_valid !== 1'b1 || rd_data !== ref_mem[i % DEPTH]) begin
        fails++; $display("FAIL stream[%0d]: got %h/%b want %h/1", i, rd_data, rd_valid, ref_mem[i % DEPTH]);
      end
    end
    rd_en = 0;
    tick();
    tests_run++;
    if (rd_valid !== 1'b0) begin
      fails++; $display("FAIL stream_end: rd_valid got %b want 0", rd_valid);
    end
  endtask

  initial begin
    test_reset();
    test_byte_enables();
    test_collision();
    test_random();
    test_clear_req();
    test_reset_mid_clear();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ram_dp_param.md
# ram_dp_param

Parametrised simple dual-port RAM: one synchronous write port with byte enables and one registered read port with a valid strobe, sharing a single clock. It replaces the fixed 4x8 single-port RAM as the storage primitive for buffers and lookup tables. A built-in clear engine zeroes the whole array after reset or on request. Read-during-write collision behaviour is selected at elaboration.

## Interface
- DATA_W, 8: word width in bits; must be a multiple of 8.
- ADDR_W, 2: address width; DEPTH = 2**ADDR_W.
- RDW_MODE, 0: same-address read/write collision; 0 = read-first (old data), 1 = write-first (new data).
- INIT_ON_RESET, 1: 1 = run a clear automatically after reset.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clr_req  in  1  request full-array clear; sampled in IDLE only.
- busy  out  1  clear in progress; ports ignored while high.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_be  in  DATA_W/8  byte enables; bit i covers wr_data[8i+7:8i].
- wr_data  in  DATA_W  write data.
- rd_en  in  1  read strobe.
- rd_addr  in  ADDR_W  read address.
- rd_data  out  DATA_W  registered read data.
- rd_valid  out  1  one-cycle strobe: rd_data updated this cycle.

## Operation
- FSM states: IDLE, CLEAR. Clear address counter clr_addr is ADDR_W bits wide.
- Reset (asynchronous, rst_n=0): rd_data=0, rd_valid=0, clr_addr=0. State = CLEAR and busy=1 if INIT_ON_RESET=1; otherwise IDLE and busy=0. Array contents are not reset directly.
- CLEAR: each edge writes 0 to mem[clr_addr] and increments clr_addr. After the edge that writes DEPTH-1, the FSM goes to IDLE, busy=0, and clr_addr wraps to 0.
- IDLE with clr_req=1 at an edge: go to CLEAR and set busy=1 from the next cycle. At that edge the write is dropped (clear has priority) and the read is still served.
- clr_req while busy=1 is ignored. There is no queued second clear.
- While busy=1: wr_en and rd_en are ignored, rd_valid=0, and rd_data holds its value.
- Write (IDLE, wr_en=1): for each byte i with wr_be[i]=1, mem[wr_addr] byte i takes wr_data byte i. All other bytes are unchanged. wr_be=0 is a no-op.
- Read (IDLE, rd_en=1): rd_data is loaded from mem[rd_addr] and rd_valid=1 for one cycle. With rd_en=0, rd_valid=0 and rd_data holds.
- Collision (rd_en and wr_en both set, rd_addr==wr_addr):
  - RDW_MODE=0: rd_data = pre-write word.
  - RDW_MODE=1: rd_data = byte-merged word (enabled bytes from wr_data, others old).
- Different-address simultaneous read and write are fully independent.
- Reset asserted mid-clear aborts the clear. On release, the clear restarts from address 0 if INIT_ON_RESET=1; otherwise the array contents are undefined-but-stable.

## Timing
- Write latency: data is visible to a read issued on the cycle after the write edge.
- Read latency: 1 cycle. rd_en at edge N gives rd_data/rd_valid valid after edge N.
- Back-to-back reads every cycle are supported, giving rd_valid continuously high.
- Clear duration: exactly DEPTH cycles of busy=1.
- Auto-clear after reset deassertion: busy falls after the DEPTH-th rising edge.
- No combinational path from any input to any output.

## Structure
- Package ram_pkg holds:
  - state enum (ST_IDLE, ST_CLEAR);
  - RDW_READ_FIRST=0 and RDW_WRITE_FIRST=1;
  - a byte-merge function (old, new, be).
- Sub-module ram_clr_fsm contains the state register, clr_addr counter and busy output. It drives a write-mux select into the array wrapper.
- The array itself is an inferred register array in ram_dp_param, with no reset on its storage.

## Test plan
All scenarios use DATA_W=16 and ADDR_W=2.
- Auto-clear: release reset with INIT_ON_RESET=1 -> busy=1 for exactly 4 cycles; reads of addresses 0-3 then return 16'h0000 with rd_valid one cycle after each rd_en.
- Byte enables: write 16'hA5C3 be=2'b11 to addr 1, then 16'hFF00 be=2'b01 to addr 1, then read addr 1 -> rd_data=16'hA500.
- Collision: addr 2 holds 16'h1234; same-edge write 16'hBEEF be=2'b10 plus read addr 2 -> 16'h1234 (RDW_MODE=0) or 16'hBE34 (RDW_MODE=1).
- Clear request: fill addresses 0-3 with nonzero data; pulse clr_req together with wr_en -> write dropped, busy=1 for 4 cycles, rd_en during busy gives rd_valid=0, all words then read 0.
- Reset mid-clear: assert rst_n=0 at cycle 2 of a clear, release -> clr_addr restarts at 0, busy=1 for a full 4 cycles, rd_data=0 and rd_valid=0 during reset.
- Streaming: rd_en high for 8 cycles over addresses 0,1,2,3,0,1,2,3 -> rd_valid high for 8 consecutive cycles, data matches the written pattern, address wraps correctly.
